// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared FSM encoding, source IDs and default widths for the UDP transmit arbiter.
// The optional round-robin tie-break is enabled with the macro UDP_TX_ARB_RR_EN.
package udp_tx_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_BE_W   = DEF_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_ARP = 2'd1,
      GNT_IP  = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_ARP = 1'b0,
      SRC_IP  = 1'b1
   } src_t;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: ARP and IP request/grant/beat handshakes plus the MAC transmit stream.
// slave is the arbiter's view; master is the view of the sources and the MAC.
interface udp_tx_arbiter_if
   import udp_tx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_W   = DATA_W / 8
);

   logic              tx_arp_req_i;
   logic              tx_arp_gnt_o;
   logic              tx_arp_data_wld_i;
   logic              tx_arp_data_ready_o;
   logic [DATA_W-1:0] tx_arp_data_i;
   logic [BE_W-1:0]   tx_arp_data_be_i;
   logic              tx_arp_data_tlast_i;

   logic              tx_ip_req_i;
   logic              tx_ip_gnt_o;
   logic              tx_ip_data_wld_i;
   logic              tx_ip_data_ready_o;
   logic [DATA_W-1:0] tx_ip_data_i;
   logic [BE_W-1:0]   tx_ip_data_be_i;
   logic              tx_ip_data_tlast_i;

   logic              mac_tx_data_wld_o;
   logic              mac_tx_data_ready_i;
   logic [DATA_W-1:0] mac_tx_data_o;
   logic [BE_W-1:0]   mac_tx_data_be_o;
   logic              mac_tx_data_tlast_o;

   modport slave (
      input  tx_arp_req_i, tx_arp_data_wld_i, tx_arp_data_i, tx_arp_data_be_i, tx_arp_data_tlast_i,
      output tx_arp_gnt_o, tx_arp_data_ready_o,
      input  tx_ip_req_i, tx_ip_data_wld_i, tx_ip_data_i, tx_ip_data_be_i, tx_ip_data_tlast_i,
      output tx_ip_gnt_o, tx_ip_data_ready_o,
      output mac_tx_data_wld_o, mac_tx_data_o, mac_tx_data_be_o, mac_tx_data_tlast_o,
      input  mac_tx_data_ready_i
   );

   modport master (
      output tx_arp_req_i, tx_arp_data_wld_i, tx_arp_data_i, tx_arp_data_be_i, tx_arp_data_tlast_i,
      input  tx_arp_gnt_o, tx_arp_data_ready_o,
      output tx_ip_req_i, tx_ip_data_wld_i, tx_ip_data_i, tx_ip_data_be_i, tx_ip_data_tlast_i,
      input  tx_ip_gnt_o, tx_ip_data_ready_o,
      input  mac_tx_data_wld_o, mac_tx_data_o, mac_tx_data_be_o, mac_tx_data_tlast_o,
      output mac_tx_data_ready_i
   );

endinterface

// File: rtl/udp_tx_skid.sv
// udp_tx_skid: 2-entry valid/ready register slice. Upstream ready is derived from registered
// occupancy only, so there is no combinational path from i_rdy to o_rdy.
module udp_tx_skid
   import udp_tx_pkg::*;
#(
   parameter int W = DEF_DATA_W + DEF_BE_W + 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_vld,
   output logic         o_rdy,
   input  logic [W-1:0] i_data,
   output logic         o_vld,
   input  logic         i_rdy,
   output logic [W-1:0] o_data
);

   logic         r_out_vld;
   logic [W-1:0] r_out;
   logic         r_sk_vld;
   logic [W-1:0] r_sk;
   logic         w_push;

   assign o_rdy  = ~r_sk_vld;
   assign w_push = i_vld & ~r_sk_vld;
   assign o_vld  = r_out_vld;
   assign o_data = r_out;

   // The skid entry only fills while the output entry is stalled, and drains first.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_vld <= 1'b0;
         r_out     <= '0;
         r_sk_vld  <= 1'b0;
         r_sk      <= '0;
      end else if (i_rdy || !r_out_vld) begin
         if (r_sk_vld) begin
            r_out     <= r_sk;
            r_out_vld <= 1'b1;
            r_sk_vld  <= 1'b0;
         end else begin
            r_out_vld <= w_push;
            if (w_push) begin
               r_out <= i_data;
            end
         end
      end else if (w_push) begin
         r_sk     <= i_data;
         r_sk_vld <= 1'b1;
      end
   end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: grants the MAC to ARP or IP for one whole frame and forwards beats via a skid stage.
// Define UDP_TX_ARB_RR_EN for round-robin ties; otherwise ARP has fixed priority.
module udp_tx_arbiter
   import udp_tx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic             clk_user_i,
   input  logic             reset_n_i,
   udp_tx_arbiter_if.slave  bus
);

   localparam int SK_W = DATA_W + BE_W + 1;

   arb_state_t      r_state;
   src_t            r_last_src;
   logic            r_gnt_arp;
   logic            r_gnt_ip;

   src_t            w_pick;
   src_t            w_tie_src;
   logic            w_in_vld;
   logic            w_sk_rdy;
   logic            w_acc;
   logic            w_out_vld;
   logic [SK_W-1:0] w_in_beat;
   logic [SK_W-1:0] w_out_beat;

`ifdef UDP_TX_ARB_RR_EN
   assign w_tie_src = (r_last_src == SRC_ARP) ? SRC_IP : SRC_ARP;
`else
   logic w_unused_last_src;
   assign w_tie_src         = SRC_ARP;
   assign w_unused_last_src = r_last_src;
`endif

   always_comb begin
      w_pick = SRC_ARP;
      if (bus.tx_arp_req_i && bus.tx_ip_req_i) begin
         w_pick = w_tie_src;
      end else if (bus.tx_ip_req_i) begin
         w_pick = SRC_IP;
      end
   end

   // Only the granted source can present a beat; in IDLE both grants are low.
   assign w_in_vld  = (r_gnt_arp & bus.tx_arp_data_wld_i) | (r_gnt_ip & bus.tx_ip_data_wld_i);
   assign w_in_beat = r_gnt_ip ?
                      {bus.tx_ip_data_i, bus.tx_ip_data_be_i, bus.tx_ip_data_tlast_i} :
                      {bus.tx_arp_data_i, bus.tx_arp_data_be_i, bus.tx_arp_data_tlast_i};
   assign w_acc     = w_in_vld & w_sk_rdy;

   assign bus.tx_arp_gnt_o        = r_gnt_arp;
   assign bus.tx_ip_gnt_o         = r_gnt_ip;
   assign bus.tx_arp_data_ready_o = r_gnt_arp & w_sk_rdy;
   assign bus.tx_ip_data_ready_o  = r_gnt_ip & w_sk_rdy;

   always_ff @(posedge clk_user_i) begin
      if (!reset_n_i) begin
         r_state    <= IDLE;
         r_last_src <= SRC_IP;
         r_gnt_arp  <= 1'b0;
         r_gnt_ip   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.tx_arp_req_i || bus.tx_ip_req_i) begin
                  r_last_src <= w_pick;
                  r_state    <= (w_pick == SRC_ARP) ? GNT_ARP : GNT_IP;
                  r_gnt_arp  <= (w_pick == SRC_ARP);
                  r_gnt_ip   <= (w_pick == SRC_IP);
               end
            end
            GNT_ARP, GNT_IP: begin
               if (w_acc && w_in_beat[0]) begin
                  r_state   <= IDLE;
                  r_gnt_arp <= 1'b0;
                  r_gnt_ip  <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_gnt_arp <= 1'b0;
               r_gnt_ip  <= 1'b0;
            end
         endcase
      end
   end

   udp_tx_skid #(.W(SK_W)) u_skid (
      .i_clk   (clk_user_i),
      .i_rst_n (reset_n_i),
      .i_vld   (w_in_vld),
      .o_rdy   (w_sk_rdy),
      .i_data  (w_in_beat),
      .o_vld   (w_out_vld),
      .i_rdy   (bus.mac_tx_data_ready_i),
      .o_data  (w_out_beat)
   );

   assign bus.mac_tx_data_wld_o   = w_out_vld;
   assign bus.mac_tx_data_o       = w_out_beat[SK_W-1 -: DATA_W];
   assign bus.mac_tx_data_be_o    = w_out_beat[BE_W:1];
   assign bus.mac_tx_data_tlast_o = w_out_beat[0];

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: randomized ARP/IP frame traffic against a queue-based model of the arbiter,
// plus directed scenarios with hand-computed grant/latency expectations.
module tb_udp_tx_arbiter;
   import udp_tx_pkg::*;

   localparam int DW = 32;
   localparam int BW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   udp_tx_arbiter_if #(.DATA_W(DW), .BE_W(BW)) bus ();

   udp_tx_arbiter #(.DATA_W(DW), .BE_W(BW)) dut (
      .clk_user_i (clk),
      .reset_n_i  (rst_n),
      .bus        (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: owner (0 none, 1 ARP, 2 IP), last granted source, buffered beats (max 2).
   logic [DW+BW:0] mq[$];
   int  m_own  = 0;
   int  m_last = 2;
   bit  m_zero = 1'b1;
   bit  m_acc [2];

   // Observed DUT events for the directed expectations.
   int gs_src[$];
   int gs_cyc[$];
   int mac_beats, mac_first, mac_tl_cyc, mac_frames, ip_stall, arp_gnt_fall, arp_tl_cyc, ip_tl_cyc;
   logic [3:0] mac_tl_be;
   logic p_ga = 1'b0, p_gi = 1'b0;

   always @(negedge clk) begin : mdl
      logic e_ga, e_gi, e_ra, e_ri, e_w, pop;
      logic [DW+BW:0] beat;
      int tie;
      e_ga = (m_own == 1);
      e_gi = (m_own == 2);
      e_ra = e_ga && (mq.size() < 2);
      e_ri = e_gi && (mq.size() < 2);
      e_w  = (mq.size() > 0);
      if (chk_en) begin
         chk("gnt_arp", 32'(bus.tx_arp_gnt_o), 32'(e_ga));
         chk("gnt_ip", 32'(bus.tx_ip_gnt_o), 32'(e_gi));
         chk("rdy_arp", 32'(bus.tx_arp_data_ready_o), 32'(e_ra));
         chk("rdy_ip", 32'(bus.tx_ip_data_ready_o), 32'(e_ri));
         chk("mac_wld", 32'(bus.mac_tx_data_wld_o), 32'(e_w));
         if (e_w) begin
            chk("mac_data", bus.mac_tx_data_o, mq[0][DW+BW:BW+1]);
            chk("mac_be", 32'(bus.mac_tx_data_be_o), 32'(mq[0][BW:1]));
            chk("mac_tlast", 32'(bus.mac_tx_data_tlast_o), 32'(mq[0][0]));
         end else if (m_zero) begin
            chk("mac_data_zero", bus.mac_tx_data_o, 32'd0);
            chk("mac_be_zero", 32'(bus.mac_tx_data_be_o), 32'd0);
            chk("mac_tlast_zero", 32'(bus.mac_tx_data_tlast_o), 32'd0);
         end
         if (bus.tx_arp_gnt_o && !p_ga) begin gs_src.push_back(1); gs_cyc.push_back(cyc); end
         if (bus.tx_ip_gnt_o && !p_gi) begin gs_src.push_back(2); gs_cyc.push_back(cyc); end
         if (!bus.tx_arp_gnt_o && p_ga) arp_gnt_fall = cyc;
         p_ga = bus.tx_arp_gnt_o;
         p_gi = bus.tx_ip_gnt_o;
         if (bus.tx_arp_gnt_o && bus.tx_arp_data_wld_i && bus.tx_arp_data_ready_o && bus.tx_arp_data_tlast_i)
            arp_tl_cyc = cyc;
         if (bus.tx_ip_gnt_o && bus.tx_ip_data_wld_i && bus.tx_ip_data_ready_o && bus.tx_ip_data_tlast_i)
            ip_tl_cyc = cyc;
         if (bus.tx_ip_gnt_o && !bus.tx_ip_data_ready_o) ip_stall++;
         if (bus.mac_tx_data_wld_o && bus.mac_tx_data_ready_i) begin
            mac_beats++;
            if (mac_beats == 1) mac_first = cyc;
            if (bus.mac_tx_data_tlast_o) begin
               mac_tl_cyc = cyc;
               mac_tl_be  = bus.mac_tx_data_be_o;
               mac_frames++;
            end
         end
      end
      if (!rst_n) begin
         mq.delete();
         m_own = 0; m_last = 2; m_zero = 1'b1;
         m_acc[0] = 1'b0; m_acc[1] = 1'b0;
      end else begin
         pop      = e_w && bus.mac_tx_data_ready_i;
         m_acc[0] = e_ra && bus.tx_arp_data_wld_i;
         m_acc[1] = e_ri && bus.tx_ip_data_wld_i;
         if (m_acc[0]) beat = {bus.tx_arp_data_i, bus.tx_arp_data_be_i, bus.tx_arp_data_tlast_i};
         else          beat = {bus.tx_ip_data_i, bus.tx_ip_data_be_i, bus.tx_ip_data_tlast_i};
         if (pop) void'(mq.pop_front());
         if (m_acc[0] || m_acc[1]) begin
            mq.push_back(beat);
            m_zero = 1'b0;
         end
         if (m_own == 0) begin
`ifdef UDP_TX_ARB_RR_EN
            tie = (m_last == 1) ? 2 : 1;
`else
            tie = 1;
`endif
            if (bus.tx_arp_req_i && bus.tx_ip_req_i) m_own = tie;
            else if (bus.tx_arp_req_i)               m_own = 1;
            else if (bus.tx_ip_req_i)                m_own = 2;
            if (m_own != 0) m_last = m_own;
         end else if ((m_acc[0] || m_acc[1]) && beat[0]) begin
            m_own = 0;
         end
      end
   end

   // Source drivers: index 0 = ARP, 1 = IP.
   int nfr[2], flen[2], bidx[2], flen_fix[2], bel_fix[2], vpct[2], drop_at[2];
   logic [DW-1:0] cdat[2];
   logic [BW-1:0] cbe[2];
   logic          ctl[2];
   int   rdy_mode = 0;
   logic tog      = 1'b1;

   task automatic new_beat(input int s);
      cdat[s] = $urandom;
      ctl[s]  = (bidx[s] == flen[s] - 1);
      cbe[s]  = ctl[s] ? ((bel_fix[s] != 0) ? 4'(bel_fix[s]) : 4'($urandom_range(1, 15))) : 4'hF;
   endtask

   task automatic new_frame(input int s);
      bidx[s] = 0;
      flen[s] = (flen_fix[s] != 0) ? flen_fix[s] : int'($urandom_range(1, 12));
      new_beat(s);
   endtask

   task automatic drive_src();
      bus.tx_arp_req_i        = (nfr[0] > 0) && !(drop_at[0] > 0 && bidx[0] >= drop_at[0]);
      bus.tx_arp_data_wld_i   = (nfr[0] > 0) && (int'($urandom_range(0, 99)) < vpct[0]);
      bus.tx_arp_data_i       = cdat[0];
      bus.tx_arp_data_be_i    = cbe[0];
      bus.tx_arp_data_tlast_i = ctl[0];
      bus.tx_ip_req_i         = (nfr[1] > 0) && !(drop_at[1] > 0 && bidx[1] >= drop_at[1]);
      bus.tx_ip_data_wld_i    = (nfr[1] > 0) && (int'($urandom_range(0, 99)) < vpct[1]);
      bus.tx_ip_data_i        = cdat[1];
      bus.tx_ip_data_be_i     = cbe[1];
      bus.tx_ip_data_tlast_i  = ctl[1];
   endtask

   task automatic drive_mac();
      case (rdy_mode)
         0:       bus.mac_tx_data_ready_i = 1'b1;
         1:       begin bus.mac_tx_data_ready_i = tog; tog = ~tog; end
         default: bus.mac_tx_data_ready_i = (int'($urandom_range(0, 99)) < 65);
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (m_acc[s]) begin
            bidx[s]++;
            if (bidx[s] == flen[s]) begin
               nfr[s]--;
               new_frame(s);
            end else begin
               new_beat(s);
            end
         end
      end
      drive_src();
      drive_mac();
   endtask

   task automatic start(input int s, input int n, input int len, input int bel, input int vp, input int drp);
      nfr[s] = n; flen_fix[s] = len; bel_fix[s] = bel; vpct[s] = vp; drop_at[s] = drp;
      new_frame(s);
      drive_src();
   endtask

   task automatic run_idle(input string nm, input int maxc);
      int k = 0;
      while (!(nfr[0] == 0 && nfr[1] == 0 && m_own == 0 && mq.size() == 0) && k < maxc) begin
         step();
         k++;
      end
      chk({nm, "_done"}, 32'(k < maxc), 32'd1);
   endtask

   task automatic clear_log();
      gs_src.delete(); gs_cyc.delete();
      mac_beats = 0; mac_first = -1; mac_tl_cyc = -1; mac_frames = 0; ip_stall = 0;
      arp_gnt_fall = -1; arp_tl_cyc = -1; ip_tl_cyc = -1; mac_tl_be = '0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_gnt_arp"}, 32'(bus.tx_arp_gnt_o), 32'd0);
      chk({nm, "_gnt_ip"}, 32'(bus.tx_ip_gnt_o), 32'd0);
      chk({nm, "_rdy_arp"}, 32'(bus.tx_arp_data_ready_o), 32'd0);
      chk({nm, "_rdy_ip"}, 32'(bus.tx_ip_data_ready_o), 32'd0);
      chk({nm, "_wld"}, 32'(bus.mac_tx_data_wld_o), 32'd0);
      chk({nm, "_data"}, bus.mac_tx_data_o, 32'd0);
      chk({nm, "_be"}, 32'(bus.mac_tx_data_be_o), 32'd0);
      chk({nm, "_tlast"}, 32'(bus.mac_tx_data_tlast_o), 32'd0);
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      int t0, k;
      int exp_ord [4];
      for (int s = 0; s < 2; s++) begin
         nfr[s] = 0; flen[s] = 1; bidx[s] = 0; flen_fix[s] = 1; bel_fix[s] = 0; vpct[s] = 100; drop_at[s] = 0;
         m_acc[s] = 1'b0; cdat[s] = '0; cbe[s] = '0; ctl[s] = 1'b0;
      end
      clear_log();
      rst_n = 1'b0;
      drive_src();
      drive_mac();
      step();
      chk_en = 1'b1;
      chk_zero("reset");
      step();
      rst_n = 1'b1;
      step();

      // ARP-only 11-beat frame, MAC always ready
      clear_log();
      start(0, 1, 11, 3, 100, 0);
      t0 = cyc;
      run_idle("arp11", 100);
      chk("arp11_gnt_src", 32'(qget(gs_src, 0)), 32'd1);
      chk("arp11_gnt_cyc", 32'(qget(gs_cyc, 0)), 32'(t0 + 1));
      chk("arp11_first_mac", 32'(mac_first), 32'(t0 + 2));
      chk("arp11_beats", 32'(mac_beats), 32'd11);
      chk("arp11_tlast_cyc", 32'(mac_tl_cyc), 32'(t0 + 12));
      chk("arp11_last_be", 32'(mac_tl_be), 32'h3);
      chk("arp11_gnt_fall", 32'(arp_gnt_fall), 32'(t0 + 12));

      // Simultaneous requests, two frames each, from a fresh reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_log();
      start(0, 2, 3, 0, 100, 0);
      start(1, 2, 3, 0, 100, 0);
      run_idle("tie", 200);
`ifdef UDP_TX_ARB_RR_EN
      exp_ord = '{1, 2, 1, 2};
`else
      exp_ord = '{1, 1, 2, 2};
`endif
      for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), 32'(qget(gs_src, i)), 32'(exp_ord[i]));
      chk("tie_frames", 32'(mac_frames), 32'd4);

      // 16-beat IP frame with MAC ready toggling 1010...
      clear_log();
      rdy_mode = 1;
      tog = 1'b1;
      start(1, 1, 16, 0, 100, 0);
      run_idle("ip16", 200);
      chk("ip16_beats", 32'(mac_beats), 32'd16);
      chk("ip16_frames", 32'(mac_frames), 32'd1);
      chk("ip16_stalled", 32'(ip_stall > 0), 32'd1);
      rdy_mode = 0;

      // IP drops its request mid-frame while ARP waits
      clear_log();
      start(1, 1, 6, 0, 100, 2);
      step(); step(); step();
      start(0, 1, 4, 0, 100, 0);
      run_idle("ipdrop", 200);
      chk("ipdrop_first", 32'(qget(gs_src, 0)), 32'd2);
      chk("ipdrop_second", 32'(qget(gs_src, 1)), 32'd1);
      chk("ipdrop_arp_gnt", 32'(qget(gs_cyc, 1)), 32'(ip_tl_cyc + 2));

      // Reset at beat 5 of a 10-beat ARP frame
      clear_log();
      start(0, 1, 10, 0, 100, 0);
      k = 0;
      while (bidx[0] < 5 && k < 50) begin step(); k++; end
      chk("rstmid_reach", 32'(k < 50), 32'd1);
      rst_n = 1'b0;
      nfr[0] = 0;
      drive_src();
      step();
      chk_zero("rstmid");
      rst_n = 1'b1;
      clear_log();
      step();
      start(0, 1, 2, 0, 100, 0);
      t0 = cyc;
      run_idle("rstmid_fresh", 100);
      chk("rstmid_gnt_cyc", 32'(qget(gs_cyc, 0)), 32'(t0 + 1));
      chk("rstmid_frames", 32'(mac_frames), 32'd1);

      // Single-beat ARP frame, IP request arrives during it
      clear_log();
      start(0, 1, 1, 0, 100, 0);
      t0 = cyc;
      step();
      start(1, 1, 3, 0, 100, 0);
      run_idle("single", 100);
      chk("single_arp_gnt", 32'(qget(gs_cyc, 0)), 32'(t0 + 1));
      chk("single_arp_fall", 32'(arp_gnt_fall), 32'(t0 + 2));
      chk("single_arp_tl", 32'(arp_tl_cyc), 32'(t0 + 1));
      chk("single_ip_src", 32'(qget(gs_src, 1)), 32'd2);
      chk("single_ip_gnt", 32'(qget(gs_cyc, 1)), 32'(t0 + 3));

      // Randomized traffic and MAC backpressure
      rdy_mode = 2;
      for (int r = 0; r < 12; r++) begin
         start(0, int'($urandom_range(0, 3)), 0, 0, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 4)) step();
         start(1, int'($urandom_range(0, 3)), 0, 0, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)));
         run_idle($sformatf("rand%0d", r), 3000);
      end

      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
